// File: rtl/commit_trace_fifo.sv
// Commit-stream trace buffer: captures retiring instructions into a small FIFO and drains them over valid/ready.
// Optional build macro COMMIT_TRACE_SEQ_EN adds a 16-bit per-commit sequence number (trace_seq).
module commit_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [31:0]      commit_pc,
    input  logic [31:0]      commit_instr,
    input  logic             commit_wreg,
    input  logic [4:0]       commit_wd,
    input  logic [31:0]      commit_wdata,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_instr,
    output logic             trace_wen,
    output logic [4:0]       trace_wnum,
    output logic [31:0]      trace_wdata,
    output logic             almost_full,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic [31:0]      commit_count
`ifdef COMMIT_TRACE_SEQ_EN
    ,
    output logic [15:0]      trace_seq
`endif
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0] AF_CNT   = CNT_BITS'(DEPTH - 1);

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    drop_count_q, drop_count_d;
    logic [31:0]         commit_count_q, commit_count_d;

    logic push;
    logic pop;
    logic push_ok;

    // Storage is split per field; contents are intentionally never reset.
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic        wen_mem   [DEPTH];
    logic [4:0]  wd_mem    [DEPTH];
    logic [31:0] wdata_mem [DEPTH];

`ifdef COMMIT_TRACE_SEQ_EN
    logic [15:0] seq_q, seq_d;
    logic [15:0] seq_mem [DEPTH];
`endif

    always_comb begin
        push    = commit_valid;
        pop     = (count_q != '0) && trace_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push_ok = push && ((count_q != FULL_CNT) || pop);

        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        overflow_d     = overflow_q;
        drop_count_d   = drop_count_q;
        commit_count_d = commit_count_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_BITS'(1);
        end

        if (push) begin
            commit_count_d = commit_count_q + 32'd1;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end
    end

`ifdef COMMIT_TRACE_SEQ_EN
    // Advances on every commit, accepted or dropped, so gaps expose losses.
    always_comb begin
        seq_d = seq_q;
        if (push) begin
            seq_d = seq_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= 16'd0;
        end else begin
            seq_q <= seq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            seq_mem[wr_ptr_q] <= seq_q;
        end
    end

    assign trace_seq = seq_mem[rd_ptr_q];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            drop_count_q   <= '0;
            commit_count_q <= 32'd0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            drop_count_q   <= drop_count_d;
            commit_count_q <= commit_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            pc_mem[wr_ptr_q]    <= commit_pc;
            instr_mem[wr_ptr_q] <= commit_instr;
            // r0 writes are folded away at capture time.
            wen_mem[wr_ptr_q]   <= commit_wreg && (commit_wd != 5'd0);
            wd_mem[wr_ptr_q]    <= commit_wd;
            wdata_mem[wr_ptr_q] <= commit_wdata;
        end
    end

    assign trace_valid  = (count_q != '0);
    assign trace_pc     = pc_mem[rd_ptr_q];
    assign trace_instr  = instr_mem[rd_ptr_q];
    assign trace_wen    = wen_mem[rd_ptr_q];
    assign trace_wnum   = wd_mem[rd_ptr_q];
    assign trace_wdata  = wdata_mem[rd_ptr_q];
    assign almost_full  = (count_q >= AF_CNT);
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
    assign commit_count = commit_count_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: directed scenarios plus random traffic against a queue-based reference.
module tb_commit_trace_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic [31:0]      commit_instr;
    logic             commit_wreg;
    logic [4:0]       commit_wd;
    logic [31:0]      commit_wdata;
    logic             trace_valid;
    logic             trace_ready;
    logic [31:0]      trace_pc;
    logic [31:0]      trace_instr;
    logic             trace_wen;
    logic [4:0]       trace_wnum;
    logic [31:0]      trace_wdata;
    logic             almost_full;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
    logic [31:0]      commit_count;
`ifdef COMMIT_TRACE_SEQ_EN
    logic [15:0]      trace_seq;
`endif

    commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .commit_wreg  (commit_wreg),
        .commit_wd    (commit_wd),
        .commit_wdata (commit_wdata),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_instr  (trace_instr),
        .trace_wen    (trace_wen),
        .trace_wnum   (trace_wnum),
        .trace_wdata  (trace_wdata),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .commit_count (commit_count)
`ifdef COMMIT_TRACE_SEQ_EN
        ,
        .trace_seq    (trace_seq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [15:0] seq;
    } ent_t;

    ent_t        q[$];
    bit          m_ovf;
    logic [15:0] m_drop;
    logic [31:0] m_cc;
    logic [15:0] m_seq;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("trace_valid", {63'd0, trace_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("trace_pc",    {32'd0, trace_pc},    {32'd0, q[0].pc});
            chk("trace_instr", {32'd0, trace_instr}, {32'd0, q[0].instr});
            chk("trace_wen",   {63'd0, trace_wen},   {63'd0, q[0].wen});
            chk("trace_wnum",  {59'd0, trace_wnum},  {59'd0, q[0].wd});
            chk("trace_wdata", {32'd0, trace_wdata}, {32'd0, q[0].wdata});
`ifdef COMMIT_TRACE_SEQ_EN
            chk("trace_seq",   {48'd0, trace_seq},   {48'd0, q[0].seq});
`endif
        end
        chk("almost_full",  {63'd0, almost_full},  {63'd0, q.size() >= DEPTH - 1});
        chk("overflow",     {63'd0, overflow},     {63'd0, m_ovf});
        chk("drop_count",   {48'd0, drop_count},   {48'd0, m_drop});
        chk("commit_count", {32'd0, commit_count}, {32'd0, m_cc});
    endtask

    // One clock: check current outputs, apply inputs, advance the reference, step past the edge.
    task automatic cycle(input bit v, input bit r, input logic [31:0] pc, input logic [31:0] instr,
                         input bit wreg, input logic [4:0] wd, input logic [31:0] wdata);
        bit   pop;
        bit   acc;
        ent_t e;
        check_outputs();
        commit_valid = v;
        trace_ready  = r;
        commit_pc    = pc;
        commit_instr = instr;
        commit_wreg  = wreg;
        commit_wd    = wd;
        commit_wdata = wdata;
        pop = (q.size() != 0) && r;
        acc = v && ((q.size() < DEPTH) || pop);
        if (pop) begin
            e = q.pop_front();
            $display("pop  pc=%08h instr=%08h wen=%0d wnum=%0d wdata=%08h seq=%0d",
                     e.pc, e.instr, e.wen, e.wd, e.wdata, e.seq);
        end
        if (v) begin
            if (acc) begin
                e.pc = pc; e.instr = instr; e.wen = wreg && (wd != 5'd0);
                e.wd = wd; e.wdata = wdata; e.seq = m_seq;
                q.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                $display("drop pc=%08h", pc);
            end
            m_cc  = m_cc + 32'd1;
            m_seq = m_seq + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rcycle(input bit v, input bit r);
        logic [4:0] wd;
        wd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cycle(v, r, $urandom, $urandom, 1'($urandom_range(0, 1)), wd, $urandom);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        commit_valid = 1'b1;
        trace_ready  = 1'b1;
        commit_pc    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        commit_valid = 1'b0;
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 16'd0;
        m_cc   = 32'd0;
        m_seq  = 16'd0;
        $display("reset");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst          = 1'b1;
        commit_valid = 1'b0;
        trace_ready  = 1'b0;
        commit_pc    = '0;
        commit_instr = '0;
        commit_wreg  = 1'b0;
        commit_wd    = '0;
        commit_wdata = '0;
        @(posedge clk);
        #1;
        do_reset();
        rcycle(0, 0);

        // Single commit with ready held high.
        cycle(1, 1, 32'h1C00_0000, 32'h0280_0C0C, 1'b1, 5'd12, 32'h3);
        chk("single_valid", {63'd0, trace_valid}, 64'd1);
        chk("single_wen",   {63'd0, trace_wen},   64'd1);
        chk("single_pc",    {32'd0, trace_pc},    64'h1C00_0000);
        cycle(0, 1, 0, 0, 0, 0, 0);
        chk("single_gone",  {63'd0, trace_valid}, 64'd0);

        // r0 write is not reported.
        cycle(1, 1, 32'h1C00_0004, 32'h0280_0000, 1'b1, 5'd0, 32'h55);
        chk("r0_wen",  {63'd0, trace_wen},  64'd0);
        chk("r0_wnum", {59'd0, trace_wnum}, 64'd0);
        cycle(0, 1, 0, 0, 0, 0, 0);

        // Fill, overflow by two, full push+pop, then drain.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 32'h1000 + 32'(i * 4), $urandom, 1'b1, 5'(i + 1), $urandom);
            if (i == 6) chk("af_after7", {63'd0, almost_full}, 64'd1);
            if (i == 7) chk("no_drop_8", {63'd0, overflow},    64'd0);
        end
        chk("ovf_set",   {63'd0, overflow},     64'd1);
        chk("drops_2",   {48'd0, drop_count},   64'd2);
        chk("commits_10",{32'd0, commit_count}, 64'd10);
        chk("head_first",{32'd0, trace_pc},     64'h1000);
        cycle(1, 1, 32'h2000, $urandom, 1'b1, 5'd3, $urandom);
        chk("full_pp_drops", {48'd0, drop_count}, 64'd2);
        for (int i = 0; i < 10; i++) rcycle(0, 1);

        // Ready toggling with continuous commits across pointer wrap.
        do_reset();
        for (int i = 0; i < 40; i++) rcycle(1, 1'(i % 2 == 0));
        for (int i = 0; i < 10; i++) rcycle(0, 1);

        // Reset with five entries buffered.
        do_reset();
        for (int i = 0; i < 5; i++) rcycle(1, 0);
        do_reset();
        chk("rst_valid", {63'd0, trace_valid},  64'd0);
        chk("rst_cc",    {32'd0, commit_count}, 64'd0);
        rcycle(1, 0);
        rcycle(0, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rcycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 10; i++) rcycle(0, 1);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
